// File: rtl/spi_slave_fsm_pkg.sv
// ============================================================================
// Package : spi_pkg
// Brief   : Shared state type, RAM command codes and width defaults.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package spi_pkg;

    localparam int SPI_RX_W = 10;
    localparam int SPI_TX_W = 8;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } spi_state_t;

endpackage

`default_nettype wire

// File: rtl/spi_slave_fsm_if.sv
// ============================================================================
// Interface : spi_slave_fsm_if
// Brief     : SPI pins plus RAM-side word handshake for spi_slave_fsm.
// Rev       : 1.0
// ============================================================================
`default_nettype none

interface spi_slave_fsm_if
    import spi_pkg::*;
#(
    parameter int RX_W = SPI_RX_W,
    parameter int TX_W = SPI_TX_W
) ();

    logic            SS_n;
    logic            MOSI;
    logic            MISO;
    logic [RX_W-1:0] rx_data;
    logic            rx_valid;
    logic [TX_W-1:0] tx_data;
    logic            tx_valid;

    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
        output MISO, rx_data, rx_valid
    );

    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid
    );

endinterface

`default_nettype wire

// File: rtl/spi_slave_fsm_piso.sv
// ============================================================================
// Module : spi_piso
// Brief  : Load/shift register putting a read byte on MISO, MSB first.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module spi_piso
    import spi_pkg::*;
#(
    parameter int W = SPI_TX_W
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         clear,
    input  wire logic         load,
    input  wire logic [W-1:0] load_data,
    output logic              miso,
    output logic              busy,
    output logic              last
);

    localparam int CW = $clog2(W);

    logic [W-1:0]  r_sr;
    logic [CW-1:0] r_left;
    logic          r_busy;
    logic          r_miso;

    // The MSB goes straight onto the line at load; r_left counts bits still queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr   <= '0;
            r_left <= '0;
            r_busy <= 1'b0;
            r_miso <= 1'b0;
        end else if (clear) begin
            r_left <= '0;
            r_busy <= 1'b0;
            r_miso <= 1'b0;
        end else if (load) begin
            r_miso <= load_data[W-1];
            r_sr   <= {load_data[W-2:0], 1'b0};
            r_left <= CW'(W - 1);
            r_busy <= 1'b1;
        end else if (r_busy) begin
            if (r_left == '0) begin
                r_miso <= 1'b0;
                r_busy <= 1'b0;
            end else begin
                r_miso <= r_sr[W-1];
                r_sr   <= {r_sr[W-2:0], 1'b0};
                r_left <= r_left - 1'b1;
            end
        end
    end

    assign miso = r_miso;
    assign busy = r_busy;
    assign last = r_busy && (r_left == '0);

endmodule

`default_nettype wire

// File: rtl/spi_slave_fsm.sv
// ============================================================================
// Module : spi_slave_fsm
// Brief  : SPI slave front end for the RAM; optional read timeout via
//          SPI_RD_TIMEOUT_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module spi_slave_fsm
    import spi_pkg::*;
#(
    parameter int RX_W       = SPI_RX_W,
    parameter int TX_W       = SPI_TX_W,
    parameter int RD_TIMEOUT = 16
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    spi_slave_fsm_if.slave   bus
);

    localparam int             CNT_W      = $clog2(RX_W);
    localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(RX_W - 1);

    spi_state_t       r_state, w_next;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [RX_W-2:0]  r_shreg;
    logic [RX_W-1:0]  r_rx_data;
    logic             r_rx_valid;
    logic             r_frame_done;
    logic             r_wait_tx;
    logic             r_rd_addr_held;

    logic w_shift, w_capture, w_load, w_timeout;
    logic w_piso_busy, w_piso_last;

    if (RD_TIMEOUT < 1) begin : g_bad_timeout
        $error("RD_TIMEOUT must be at least 1");
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_shift   = 1'b0;
        w_capture = 1'b0;
        w_load    = 1'b0;
        case (r_state)
            IDLE: begin
                if (!bus.SS_n) w_next = CHK_CMD;
            end
            CHK_CMD: begin
                if (bus.SS_n) begin
                    w_next = IDLE;
                end else begin
                    w_shift = 1'b1;
                    if (!bus.MOSI)           w_next = WRITE;
                    else if (r_rd_addr_held) w_next = READ_DATA;
                    else                     w_next = READ_ADD;
                end
            end
            default: begin
                if (bus.SS_n) begin
                    w_next = IDLE;
                end else if (!r_frame_done) begin
                    w_shift   = 1'b1;
                    w_capture = (r_bit_cnt == C_LAST_BIT);
                end else if ((r_state == READ_DATA) && r_wait_tx && bus.tx_valid) begin
                    w_load = 1'b1;
                end
            end
        endcase
    end

    // SS_n high aborts everything; the held read address survives unless the byte was already going out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt      <= '0;
            r_shreg        <= '0;
            r_rx_data      <= '0;
            r_rx_valid     <= 1'b0;
            r_frame_done   <= 1'b0;
            r_wait_tx      <= 1'b0;
            r_rd_addr_held <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (bus.SS_n) begin
                r_bit_cnt    <= '0;
                r_frame_done <= 1'b0;
                r_wait_tx    <= 1'b0;
                if (w_piso_busy) r_rd_addr_held <= 1'b0;
            end else begin
                if (w_shift) begin
                    r_shreg   <= {r_shreg[RX_W-3:0], bus.MOSI};
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
                if (w_capture) begin
                    r_rx_data    <= {r_shreg, bus.MOSI};
                    r_rx_valid   <= 1'b1;
                    r_frame_done <= 1'b1;
                    r_bit_cnt    <= '0;
                    r_wait_tx    <= (r_state == READ_DATA);
                    if (r_state == READ_ADD) r_rd_addr_held <= 1'b1;
                end
                if (w_load || w_timeout) r_wait_tx <= 1'b0;
                if (w_piso_last || w_timeout) r_rd_addr_held <= 1'b0;
            end
        end
    end

`ifdef SPI_RD_TIMEOUT_EN
    localparam int TO_W = $clog2(RD_TIMEOUT + 1);
    logic [TO_W-1:0] r_to_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        r_to_cnt <= '0;
        else if (w_capture)                r_to_cnt <= '0;
        else if (r_wait_tx && !bus.SS_n)   r_to_cnt <= r_to_cnt + 1'b1;
    end

    assign w_timeout = r_wait_tx && !bus.SS_n && !bus.tx_valid &&
                       (r_to_cnt == TO_W'(RD_TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    spi_piso #(.W(TX_W)) u_piso (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (bus.SS_n),
        .load      (w_load),
        .load_data (bus.tx_data),
        .miso      (bus.MISO),
        .busy      (w_piso_busy),
        .last      (w_piso_last)
    );

    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_fsm.sv
// ============================================================================
// Module : tb_spi_slave_fsm
// Brief  : Self-checking bench: directed frame table, corner sequences and
//          random frames against a frame-level model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_spi_slave_fsm;
    import spi_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    spi_slave_fsm_if #(.RX_W(10), .TX_W(8)) bus ();

    spi_slave_fsm #(.RX_W(10), .TX_W(8), .RD_TIMEOUT(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

`ifdef SPI_RD_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    int total = 0;
    int bad   = 0;
    bit m_held = 1'b0;

    typedef struct {
        logic [9:0] word;
        int         nbits;
        logic [7:0] tx_byte;
        int         tx_delay;
        bit         exp_valid;
        bit         exp_shift;
        bit         exp_held;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input logic [9:0] word, input int nbits, input logic [7:0] tx_byte,
                             input int tx_delay, input bit exp_valid, input bit exp_shift,
                             input bit exp_held);
        int strobes = 0;
        int miso_hi = 0;
        logic [7:0] got;
        bus.SS_n = 1'b0;
        bus.MOSI = 1'($urandom);
        step();
        strobes += int'(bus.rx_valid);
        for (int i = 0; i < nbits; i++) begin
            bus.MOSI = word[9-i];
            step();
            if (i == 9) begin
                chk("rx_valid", 32'(bus.rx_valid), 32'(exp_valid));
                if (exp_valid) chk("rx_data", 32'(bus.rx_data), 32'(word));
            end else begin
                strobes += int'(bus.rx_valid);
            end
        end
        if (nbits < 10) begin
            bus.SS_n = 1'b1;
            bus.MOSI = 1'($urandom);
            step();
            strobes += int'(bus.rx_valid);
            chk("abort_state", 32'(dut.r_state), 32'(IDLE));
            chk("abort_strobes", 32'(strobes), 32'(0));
            chk("abort_held", 32'(dut.r_rd_addr_held), 32'(exp_held));
            return;
        end
        if (exp_shift) begin
            for (int d = 0; d < tx_delay; d++) begin
                bus.MOSI = 1'($urandom);
                step();
                strobes += int'(bus.rx_valid);
                miso_hi += int'(bus.MISO);
            end
            chk("miso_wait", 32'(miso_hi), 32'(0));
            bus.tx_valid = 1'b1;
            bus.tx_data  = tx_byte;
            step();
            bus.tx_valid = 1'b0;
            bus.tx_data  = 8'($urandom);
            got[7] = bus.MISO;
            for (int b = 6; b >= 0; b--) begin
                bus.MOSI = 1'($urandom);
                step();
                strobes += int'(bus.rx_valid);
                got[b] = bus.MISO;
            end
            chk("miso_byte", 32'(got), 32'(tx_byte));
            step();
            chk("miso_after", 32'(bus.MISO), 32'(0));
        end else begin
            for (int c = 0; c < 6; c++) begin
                bus.MOSI = 1'($urandom);
                if (!word[9] && c == 2) begin
                    bus.tx_valid = 1'b1;
                    bus.tx_data  = 8'($urandom);
                end
                step();
                bus.tx_valid = 1'b0;
                strobes += int'(bus.rx_valid);
                miso_hi += int'(bus.MISO);
            end
            chk("miso_quiet", 32'(miso_hi), 32'(0));
        end
        chk("held", 32'(dut.r_rd_addr_held), 32'(exp_held));
        bus.SS_n = 1'b1;
        step();
        strobes += int'(bus.rx_valid);
        chk("extra_strobes", 32'(strobes), 32'(0));
    endtask

    // Read-data frame that the RAM never answers; held flag expected to be set on entry.
    task automatic read_no_tx(input logic [9:0] word);
        int miso_hi = 0;
        bus.SS_n = 1'b0;
        step();
        for (int i = 0; i < 10; i++) begin
            bus.MOSI = word[9-i];
            step();
        end
        chk("notx_rx_valid", 32'(bus.rx_valid), 32'(1));
        chk("notx_rx_data", 32'(bus.rx_data), 32'(word));
        for (int w = 1; w <= 20; w++) begin
            bus.MOSI = 1'($urandom);
            step();
            miso_hi += int'(bus.MISO);
            if (w == 15) chk("held_pre_timeout", 32'(dut.r_rd_addr_held), 32'(1));
            if (w == 16) chk("held_post_timeout", 32'(dut.r_rd_addr_held), 32'(!TO_EN));
        end
        chk("notx_miso", 32'(miso_hi), 32'(0));
        bus.SS_n = 1'b1;
        step();
        chk("notx_held_after_abort", 32'(dut.r_rd_addr_held), 32'(!TO_EN));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] w;
        int         nb;
        bit         ev, es, eh;
        logic [7:0] got;

        bus.SS_n = 1'b1; bus.MOSI = 1'b0; bus.tx_valid = 1'b0; bus.tx_data = '0;

        vecs[0]  = '{10'h05A, 10, 8'h00, 0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{10'h15A, 10, 8'h00, 0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{10'h25A, 10, 8'h00, 0, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{10'h3A5, 10, 8'hC3, 1, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{10'h0F0,  5, 8'h00, 0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{10'h0F0, 10, 8'h00, 0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{10'h211, 10, 8'h00, 0, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{10'h3C3,  3, 8'h00, 0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{10'h3FF, 10, 8'h5A, 0, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{10'h377, 10, 8'h00, 0, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{10'h200, 10, 8'h81, 2, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{10'h1F0,  9, 8'h00, 0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{10'h155, 10, 8'h00, 0, 1'b1, 1'b0, 1'b0};

        #3;
        chk("reset_rx_valid", 32'(bus.rx_valid), 32'(0));
        chk("reset_rx_data", 32'(bus.rx_data), 32'(0));
        chk("reset_miso", 32'(bus.MISO), 32'(0));
        chk("reset_state", 32'(dut.r_state), 32'(IDLE));
        chk("reset_held", 32'(dut.r_rd_addr_held), 32'(0));
        step(); step();
        rst_n = 1'b1;
        step();

        for (int v = 0; v < 13; v++) begin
            run_frame(vecs[v].word, vecs[v].nbits, vecs[v].tx_byte, vecs[v].tx_delay,
                      vecs[v].exp_valid, vecs[v].exp_shift, vecs[v].exp_held);
        end
        m_held = 1'b0;

        // Abort during shift-out clears the held address.
        run_frame(10'h2AA, 10, 8'h00, 0, 1'b1, 1'b0, 1'b1);
        bus.SS_n = 1'b0; step();
        for (int i = 0; i < 10; i++) begin bus.MOSI = w[0]; bus.MOSI = 1'($urandom); bus.MOSI = (i < 2) ? 1'b1 : bus.MOSI; step(); end
        bus.tx_valid = 1'b1; bus.tx_data = 8'hC3; step(); bus.tx_valid = 1'b0;
        got[7] = bus.MISO; step(); got[6] = bus.MISO;
        chk("abort_out_bits", 32'(got[7:6]), 32'(2'b11));
        bus.SS_n = 1'b1; step();
        chk("abort_out_miso", 32'(bus.MISO), 32'(0));
        chk("abort_out_held", 32'(dut.r_rd_addr_held), 32'(0));

        // Asynchronous reset mid shift-out of 8'hC3.
        run_frame(10'h2C0, 10, 8'h00, 0, 1'b1, 1'b0, 1'b1);
        bus.SS_n = 1'b0; step();
        for (int i = 0; i < 10; i++) begin bus.MOSI = (i < 2) ? 1'b1 : 1'b0; step(); end
        bus.tx_valid = 1'b1; bus.tx_data = 8'hC3; step(); bus.tx_valid = 1'b0;
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_miso", 32'(bus.MISO), 32'(0));
        chk("rst_mid_rx_valid", 32'(bus.rx_valid), 32'(0));
        chk("rst_mid_held", 32'(dut.r_rd_addr_held), 32'(0));
        chk("rst_mid_state", 32'(dut.r_state), 32'(IDLE));
        bus.SS_n = 1'b1;
        step();
        rst_n = 1'b1;
        step();

        // Unanswered read: waits forever by default, abandons after RD_TIMEOUT when enabled.
        run_frame(10'h2E1, 10, 8'h00, 0, 1'b1, 1'b0, 1'b1);
        read_no_tx(10'h3E1);
        if (!TO_EN) begin
            run_frame(10'h3AA, 10, 8'h96, 1, 1'b1, 1'b1, 1'b0);
        end else begin
            run_frame(10'h3AA, 10, 8'h00, 0, 1'b1, 1'b0, 1'b1);
            run_frame(10'h3AB, 10, 8'h96, 1, 1'b1, 1'b1, 1'b0);
        end
        m_held = 1'b0;

        for (int n = 0; n < 40; n++) begin
            w  = 10'($urandom);
            nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 9)) : 10;
            ev = (nb == 10);
            es = 1'b0;
            eh = m_held;
            if (ev && w[9]) begin
                if (m_held) begin
                    es = 1'b1;
                    eh = 1'b0;
                end else begin
                    eh = 1'b1;
                end
            end
            run_frame(w, nb, 8'($urandom), int'($urandom_range(0, 3)), ev, es, eh);
            m_held = eh;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_slave_fsm.md
Name: spi_slave_fsm

Overview:
- Serial front end directly upstream of the single-port RAM.
- Deserialises MOSI frames into 10-bit command/data words (rx_data, rx_valid) for the RAM.
- Captures the RAM's 8-bit read result (tx_data, tx_valid) and serialises it MSB-first on MISO.
- Sits between the chip-level SPI pins and the RAM inside the SPI wrapper.

Parameters:
- RX_W, 10, width of the word delivered to the RAM: bits [9:8] are the command, bits [7:0] are address or data.
- TX_W, 8, width of the read word returned by the RAM.
- RD_TIMEOUT, 16, cycles to wait for tx_valid (used only with SPI_RD_TIMEOUT_EN).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- SS_n  input  1  slave select, active low; frames a transaction.
- MOSI  input  1  serial data in, MSB first, sampled on clk rising edge.
- tx_data  input  TX_W  read data from the RAM.
- tx_valid  input  1  tx_data is valid; a one-cycle pulse.
- MISO  output  1  serial read data out, registered.
- rx_data  output  RX_W  assembled word to the RAM.
- rx_valid  output  1  one-cycle strobe qualifying rx_data.

Behaviour:
- Interface fixed: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE; rx_data=0; rx_valid=0; MISO=0; bit counter=0; rd_addr_held=0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: while SS_n=1, stay in IDLE. On a clk edge with SS_n=0, go to CHK_CMD; MOSI is not sampled on that edge.
- CHK_CMD: sample MOSI into shift bit 9.
  - MOSI=0: go to WRITE.
  - MOSI=1 and rd_addr_held=0: go to READ_ADD.
  - MOSI=1 and rd_addr_held=1: go to READ_DATA.
- WRITE, READ_ADD, READ_DATA: shift in 9 more MOSI bits, MSB first (10 bits total including the CHK_CMD bit).
- On the edge capturing the 10th bit: rx_data gets the full word and rx_valid=1 for exactly one cycle. First-bit-to-rx_valid latency is 10 clk edges.
- After rx_valid in WRITE or READ_ADD: hold state and ignore MOSI until SS_n=1. READ_ADD sets rd_addr_held=1 on its rx_valid.
- After rx_valid in READ_DATA: wait for tx_valid.
  - On tx_valid=1, latch tx_data.
  - Starting the next cycle, drive MISO with bits 7..0, one per clk (8 cycles).
  - After bit 0, MISO returns to 0, rd_addr_held clears, and the block idles until SS_n=1.
  - tx_valid outside this wait window is ignored.
- Command bits rx_data[9:8] are passed through unmodified. The FSM does not check that bit 8 matches the state; the RAM decodes it.
- SS_n=1 in any state: next state is IDLE, counter cleared, MISO=0, and no rx_valid is issued for a partial frame.
  - rd_addr_held keeps its value on abort, except that it clears if the abort occurs during or after the READ_DATA shift-out.
- SS_n=1 on the same edge as the 10th bit: the abort wins and rx_valid is not asserted.
- Reset mid-frame: immediate return to reset values.
- Only one outstanding read; no buffering beyond the single tx latch.

Optional Feature:
- Macro: SPI_RD_TIMEOUT_EN.
- Defined: in READ_DATA, a counter starts at rx_valid. If tx_valid has not arrived after RD_TIMEOUT cycles:
  - abandon the read (MISO stays 0);
  - clear rd_addr_held;
  - hold until SS_n=1.
- Undefined: the block waits indefinitely for tx_valid; no counter logic is generated.

Decomposition:
- Package spi_pkg holds:
  - the state enum type;
  - command constants CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11;
  - RX_W and TX_W defaults.
- Sub-module spi_piso: an 8-bit load/shift register with done flag, driving MISO. Deserialisation and the FSM stay in the top module.

Test Plan:
- Write-address frame: SS_n low, MOSI 0,0,0x5A MSB-first (10 bits after CHK_CMD) → one rx_valid pulse with rx_data=10'h05A at 10 edges after CHK_CMD; no further strobes until SS_n high.
- Write-data frame, then read-address frame (bits 1,0,0x5A) → rx_data=10'h15A, then 10'h25A; rd_addr_held=1 after the second frame.
- Read-data frame (bits 1,1,xx) with RAM model returning tx_valid one cycle after rx_valid and tx_data=8'hC3 → rx_data[9:8]=2'b11; MISO outputs 1,1,0,0,0,0,1,1 on the 8 cycles after tx_valid; rd_addr_held then 0.
- Abort: SS_n high after 5 bits of a write frame → no rx_valid, state IDLE next cycle; the next full frame decodes correctly.
- Reset assertion mid shift-out of 8'hC3 → MISO=0 and rx_valid=0 immediately; rd_addr_held=0.
- With SPI_RD_TIMEOUT_EN and no tx_valid → MISO stays 0; after 16 cycles a new read-data frame routes to READ_ADD (rd_addr_held cleared).
